// File: rtl/maquina_pkg.sv
// Shared definitions for the vending machine coin paths: coin codes, coin
// values in R$0.25 units and the debug state codes of the change dispenser.
package maquina_pkg;

    // AB coin codes, identical to the ones used by the coin acceptor
    localparam logic [1:0] MOEDA_NENHUMA = 2'b00;
    localparam logic [1:0] MOEDA_25      = 2'b01;
    localparam logic [1:0] MOEDA_50      = 2'b10;
    localparam logic [1:0] MOEDA_100     = 2'b11;

    // Coin values in quarter units
    localparam logic [2:0] VALOR_25  = 3'd1;
    localparam logic [2:0] VALOR_50  = 3'd2;
    localparam logic [2:0] VALOR_100 = 3'd4;

    // Dispenser state codes, exported as-is on the debug port
    localparam logic [2:0] EST_OCIOSO    = 3'd0;
    localparam logic [2:0] EST_CALCULA   = 3'd1;
    localparam logic [2:0] EST_SELECIONA = 3'd2;
    localparam logic [2:0] EST_EJETA     = 3'd3;
    localparam logic [2:0] EST_FIM       = 3'd4;
    localparam logic [2:0] EST_ERRO      = 3'd5;

    // Value in quarter units of a coin code; "no coin" is worth nothing
    function automatic logic [2:0] valor_da_moeda(input logic [1:0] codigo);
        logic [2:0] valor;
        case (codigo)
            MOEDA_25:  valor = VALOR_25;
            MOEDA_50:  valor = VALOR_50;
            MOEDA_100: valor = VALOR_100;
            default:   valor = 3'd0;
        endcase
        return valor;
    endfunction

endpackage

// File: rtl/seletor_de_moeda.sv
// Greedy coin picker: for the remaining change, chooses the largest coin that
// does not exceed it. Purely combinational so it can be tested on its own.
module seletor_de_moeda
    import maquina_pkg::*;
#(
    parameter int W = 6
) (
    input  logic [W-1:0] troco,
    output logic [1:0]   codigo,
    output logic [2:0]   valor
);

    // Largest coin first; a quarter is the fallback for any odd remainder
    always_comb begin
        codigo = MOEDA_25;
        if (troco >= W'(4)) begin
            codigo = MOEDA_100;
        end else if (troco >= W'(2)) begin
            codigo = MOEDA_50;
        end
        valor = valor_da_moeda(codigo);
    end

endmodule

// File: rtl/dispensador_de_troco.sv
// Change dispenser: latches the balance, subtracts the product price and
// hands the change out one coin at a time over a valid/ack handshake with
// the coin ejector, giving up with an error pulse if the ejector jams.
module dispensador_de_troco
    import maquina_pkg::*;
#(
    parameter int W       = 6,
    parameter int PRECO   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         iniciar,
    input  logic [W-1:0] saldo_in,
    input  logic         ejetor_ack,
    output logic [1:0]   moeda_out,
    output logic         moeda_valid,
    output logic         ocupado,
    output logic         concluido,
    output logic         erro,
    output logic [2:0]   estado
);

    localparam int            CW      = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]  PRECO_W = W'(PRECO);
    localparam logic [CW-1:0] LIMITE  = CW'(TIMEOUT);

    logic [2:0]    estado_q;
    logic [W-1:0]  saldo_q;
    logic [W-1:0]  troco_q;
    logic [CW-1:0] contador_q;
    logic [1:0]    codigo_sel;
    logic [2:0]    valor_sel;
    logic [W-1:0]  troco_restante;

    // The coin under ejection is always the greedy pick for the current
    // change, since the change only moves once the ejector acknowledges.
    seletor_de_moeda #(
        .W(W)
    ) u_seletor (
        .troco (troco_q),
        .codigo(codigo_sel),
        .valor (valor_sel)
    );

    assign troco_restante = troco_q - W'(valor_sel);

    // Main sequencer: accept request, compute change, then loop select/eject
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q    <= EST_OCIOSO;
            saldo_q     <= '0;
            troco_q     <= '0;
            contador_q  <= '0;
            moeda_out   <= MOEDA_NENHUMA;
            moeda_valid <= 1'b0;
        end else begin
            case (estado_q)
                EST_OCIOSO: begin
                    if (iniciar) begin
                        saldo_q  <= saldo_in;
                        estado_q <= EST_CALCULA;
                    end
                end
                EST_CALCULA: begin
                    if (saldo_q < PRECO_W) begin
                        estado_q <= EST_ERRO;
                    end else begin
                        troco_q  <= saldo_q - PRECO_W;
                        estado_q <= (saldo_q == PRECO_W) ? EST_FIM : EST_SELECIONA;
                    end
                end
                EST_SELECIONA: begin
                    moeda_out   <= codigo_sel;
                    moeda_valid <= 1'b1;
                    contador_q  <= '0;
                    estado_q    <= EST_EJETA;
                end
                EST_EJETA: begin
                    if (ejetor_ack) begin
                        troco_q     <= troco_restante;
                        moeda_out   <= MOEDA_NENHUMA;
                        moeda_valid <= 1'b0;
                        estado_q    <= (troco_restante == '0) ? EST_FIM : EST_SELECIONA;
                    end else if (contador_q == LIMITE) begin
                        moeda_out   <= MOEDA_NENHUMA;
                        moeda_valid <= 1'b0;
                        estado_q    <= EST_ERRO;
                    end else begin
                        contador_q <= contador_q + CW'(1);
                    end
                end
                EST_FIM: begin
                    estado_q <= EST_OCIOSO;
                end
                EST_ERRO: begin
                    troco_q  <= '0;
                    estado_q <= EST_OCIOSO;
                end
                default: begin
                    moeda_out   <= MOEDA_NENHUMA;
                    moeda_valid <= 1'b0;
                    estado_q    <= EST_OCIOSO;
                end
            endcase
        end
    end

    // Status pulses come straight from the state register, so each lasts
    // exactly the single cycle spent in FIM or ERRO.
    always_comb begin
        ocupado   = (estado_q != EST_OCIOSO);
        concluido = (estado_q == EST_FIM);
        erro      = (estado_q == EST_ERRO);
        estado    = estado_q;
    end

endmodule

// File: tb/tb_dispensador_de_troco.sv
// Self-checking bench for the change dispenser. Expected coin sequences come
// from plain arithmetic on the change amount; the bench plays the ejector.
module tb_dispensador_de_troco;

    localparam int W       = 6;
    localparam int PRECO   = 5;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0;
    logic         reset;
    logic         iniciar;
    logic [W-1:0] saldo_in;
    logic         ejetor_ack;
    logic [1:0]   moeda_out;
    logic         moeda_valid;
    logic         ocupado;
    logic         concluido;
    logic         erro;
    logic [2:0]   estado;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dispensador_de_troco #(
        .W(W),
        .PRECO(PRECO),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .iniciar    (iniciar),
        .saldo_in   (saldo_in),
        .ejetor_ack (ejetor_ack),
        .moeda_out  (moeda_out),
        .moeda_valid(moeda_valid),
        .ocupado    (ocupado),
        .concluido  (concluido),
        .erro       (erro),
        .estado     (estado)
    );

    // All outputs packed together for one-shot comparison
    function automatic logic [8:0] obs();
        return {ocupado, moeda_valid, moeda_out, concluido, erro, estado};
    endfunction

    // Outputs expected in a given state code with a given coin on offer
    function automatic logic [8:0] esperado(input logic [2:0] est, input logic [1:0] moeda);
        return {est != 3'd0, est == 3'd3, (est == 3'd3) ? moeda : 2'b00,
                est == 3'd4, est == 3'd5, est};
    endfunction

    // Complete transaction against the greedy-change model, with ack delays in
    // [dmin,dmax] and optional iniciar noise while a coin is pending
    task automatic run_troco(input int saldo, input int dmin, input int dmax,
                             input bit ruido, input string nome);
        int         c;
        int         d;
        int         moedas[$];
        logic [1:0] cod;
        logic [8:0] e;
        if (saldo >= PRECO) begin
            c = saldo - PRECO;
            repeat (c / 4) moedas.push_back(3);
            repeat ((c % 4) / 2) moedas.push_back(2);
            repeat (c % 2) moedas.push_back(1);
        end
        @(negedge clk);
        saldo_in = W'(saldo);
        iniciar  = 1'b1;
        @(negedge clk);
        iniciar  = 1'b0;
        saldo_in = W'($urandom);
        e = esperado(3'd1, 2'b00);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("[TB] FAIL %s calcula obs=%b exp=%b", nome, obs(), e);
        end
        if (saldo < PRECO) begin
            @(negedge clk);
            e = esperado(3'd5, 2'b00);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("[TB] FAIL %s erro_pulso obs=%b exp=%b", nome, obs(), e);
            end
        end else if (moedas.size() == 0) begin
            @(negedge clk);
            e = esperado(3'd4, 2'b00);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("[TB] FAIL %s concluido_zero obs=%b exp=%b", nome, obs(), e);
            end
        end else begin
            @(negedge clk);
            e = esperado(3'd2, 2'b00);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("[TB] FAIL %s seleciona obs=%b exp=%b", nome, obs(), e);
            end
            for (int i = 0; i < moedas.size(); i++) begin
                cod = 2'(moedas[i]);
                @(negedge clk);
                e = esperado(3'd3, cod);
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("[TB] FAIL %s moeda%0d obs=%b exp=%b", nome, i, obs(), e);
                end
                d = $urandom_range(dmax, dmin);
                for (int k = 0; k < d; k++) begin
                    if (ruido) begin
                        iniciar  = 1'($urandom_range(1, 0));
                        saldo_in = W'($urandom);
                    end
                    @(negedge clk);
                    iniciar = 1'b0;
                    checks++;
                    if (obs() !== e) begin
                        errors++;
                        $display("[TB] FAIL %s espera%0d obs=%b exp=%b", nome, i, obs(), e);
                    end
                end
                ejetor_ack = 1'b1;
                @(negedge clk);
                ejetor_ack = 1'b0;
                e = esperado((i == moedas.size() - 1) ? 3'd4 : 3'd2, 2'b00);
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("[TB] FAIL %s apos_ack%0d obs=%b exp=%b", nome, i, obs(), e);
                end
            end
        end
        @(negedge clk);
        e = esperado(3'd0, 2'b00);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("[TB] FAIL %s volta_ocioso obs=%b exp=%b", nome, obs(), e);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        iniciar    = 1'b0;
        ejetor_ack = 1'b0;
        saldo_in   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset obs=%b exp=%b", obs(), 9'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 9'd0) begin
            errors++;
            $display("[TB] FAIL pos_reset obs=%b exp=%b", obs(), 9'd0);
        end
    endtask

    task automatic test_timeout();
        logic [8:0] e;
        @(negedge clk);
        saldo_in = W'(9);
        iniciar  = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        @(negedge clk);
        for (int k = 0; k <= TIMEOUT; k++) begin
            @(negedge clk);
            e = esperado(3'd3, 2'b11);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("[TB] FAIL timeout_espera%0d obs=%b exp=%b", k, obs(), e);
            end
        end
        @(negedge clk);
        e = esperado(3'd5, 2'b00);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("[TB] FAIL timeout_erro obs=%b exp=%b", obs(), e);
        end
        @(negedge clk);
        checks++;
        if (obs() !== 9'd0) begin
            errors++;
            $display("[TB] FAIL timeout_volta obs=%b exp=%b", obs(), 9'd0);
        end
    endtask

    task automatic test_ignora_ocupado();
        logic [8:0] e;
        @(negedge clk);
        saldo_in = W'(5);
        iniciar  = 1'b1;
        @(negedge clk);
        saldo_in = W'(63);
        @(negedge clk);
        iniciar = 1'b0;
        e = esperado(3'd4, 2'b00);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("[TB] FAIL ocupado_fim obs=%b exp=%b", obs(), e);
        end
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (obs() !== 9'd0) begin
                errors++;
                $display("[TB] FAIL ocupado_ignorado obs=%b exp=%b", obs(), 9'd0);
            end
        end
    endtask

    task automatic test_reset_meio();
        logic [8:0] e;
        @(negedge clk);
        saldo_in = W'(63);
        iniciar  = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        repeat (2) @(negedge clk);
        e = esperado(3'd3, 2'b11);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("[TB] FAIL reset_meio_ejeta obs=%b exp=%b", obs(), e);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_meio obs=%b exp=%b", obs(), 9'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== 9'd0) begin
            errors++;
            $display("[TB] FAIL reset_meio_depois obs=%b exp=%b", obs(), 9'd0);
        end
    endtask

    task automatic test_aleatorio();
        for (int n = 0; n < 12; n++) begin
            run_troco($urandom_range(63, 0), 0, 4, 1'b1, "aleatorio");
        end
    endtask

    initial begin
        test_reset();
        run_troco(9, 2, 2, 1'b0, "troco_unico");
        run_troco(8, 0, 3, 1'b0, "duas_moedas");
        run_troco(5, 0, 0, 1'b0, "troco_zero");
        run_troco(3, 0, 0, 1'b0, "saldo_insuficiente");
        run_troco(63, 0, 2, 1'b0, "saldo_maximo");
        run_troco(9, TIMEOUT, TIMEOUT, 1'b0, "ack_no_limite");
        test_timeout();
        test_ignora_ocupado();
        test_reset_meio();
        test_aleatorio();
        run_troco(6, 0, 1, 1'b1, "back_to_back");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a hang anywhere in the sequence
    initial begin
        #500000;
        $display("[TB] FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
